fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 177 +++++++++++++++++
 tb/tb_fetch_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch stage of the five-stage RISC-V pipeline.
//
// Owns the fetch PC (PCF) and keeps at most one request outstanding to
// instruction memory. It drives the IF/ID register that feeds decode. When no
// instruction is available, a NOP bubble (ValidD = 0) is written instead.
//
// Build option: define FETCH_SKID_EN to add a one-entry skid buffer (HOLD
// state). The buffer catches a response that arrives while decode is stalled.
// Without it, such a response is dropped and the same PC is fetched again.
//
// Ports
//   clk         pipeline clock, rising edge
//   rst_n       asynchronous active-low reset
//   StallF      hold PCF, issue no new request
//   StallD      hold IF/ID contents (also masks PCSrcD)
//   PCSrcD      taken branch/jump resolved in decode
//   PCBranchD   redirect target
//   ImemReq     one-cycle request strobe (combinational in REQ)
//   ImemAddr    request address, always PCF
//   ImemRValid  one-cycle response strobe
//   ImemRData   response instruction
//   InstrD      IF/ID instruction
//   PCD         IF/ID PC
//   PCPlus4D    IF/ID PC+4
//   ValidD      IF/ID holds a real instruction
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemRValid,
  input  logic [31:0] ImemRData,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
`ifdef FETCH_SKID_EN
    ,
    HOLD = 2'd3
`endif
  } state_t;

  state_t      state;
  logic [31:0] pcF;
  logic        discard;
  logic        redirect;
  logic        ifidLoad;
  logic [31:0] ifidInstr;
  logic [31:0] ifidPc;

  function automatic logic [31:0] pcInc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // A branch is ignored while decode is stalled: its operands may not be
  // ready yet.
  assign redirect = PCSrcD && !StallD;

  // A request is suppressed in a redirect cycle, so the stale PC is never
  // fetched. The request one cycle later uses the branch target.
  assign ImemReq  = (state == REQ) && !StallF && !redirect;
  assign ImemAddr = pcF;

  // ---- IF: PC register and request FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pcF     <= RESET_PC;
      discard <= 1'b0;
    end else if (redirect) begin
      pcF <= PCBranchD;
      // If a request is still in flight, wait for it and throw its data away.
      if (state == WAIT && !ImemRValid) begin
        discard <= 1'b1;
        state   <= WAIT;
      end else begin
        discard <= 1'b0;
        state   <= REQ;
      end
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (ImemReq) state <= WAIT;
        end
        WAIT: begin
          if (ImemRValid) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= REQ;
            end else if (StallD) begin
`ifdef FETCH_SKID_EN
              pcF   <= pcInc(pcF);
              state <= HOLD;
`else
              state <= REQ;
`endif
            end else begin
              pcF   <= pcInc(pcF);
              state <= REQ;
            end
          end
        end
`ifdef FETCH_SKID_EN
        HOLD: begin
          if (!StallD) state <= REQ;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_SKID_EN
  logic [31:0] skidInstr_p0;
  logic [31:0] skidPc_p0;

  // ---- IF: skid buffer (data only, validity is the HOLD state) ----
  always_ff @(posedge clk) begin
    if (state == WAIT && ImemRValid && !discard && StallD && !redirect) begin
      skidInstr_p0 <= ImemRData;
      skidPc_p0    <= pcF;
    end
  end
`endif

  always_comb begin
    ifidLoad  = 1'b0;
    ifidInstr = ImemRData;
    ifidPc    = pcF;
    if (state == WAIT && ImemRValid && !discard) ifidLoad = 1'b1;
`ifdef FETCH_SKID_EN
    if (state == HOLD) begin
      ifidLoad  = 1'b1;
      ifidInstr = skidInstr_p0;
      ifidPc    = skidPc_p0;
    end
`endif
  end

  // ---- IF/ID boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'h0;
      PCPlus4D <= 32'h0;
      ValidD   <= 1'b0;
    end else if (redirect) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (!StallD) begin
      if (ifidLoad) begin
        InstrD   <= ifidInstr;
        PCD      <= ifidPc;
        PCPlus4D <= pcInc(ifidPc);
        ValidD   <= 1'b1;
      end else begin
        InstrD <= NOP_INSTR;
        ValidD <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        StallF = 1'b0, StallD = 1'b0, PCSrcD = 1'b0;
  logic [31:0] PCBranchD = 32'h0;
  logic        ImemRValid = 1'b0;
  logic [31:0] ImemRData = 32'h0;
  logic        ImemReq, ValidD, ImemReq2, ValidD2;
  logic [31:0] ImemAddr, InstrD, PCD, PCPlus4D;
  logic [31:0] ImemAddr2, InstrD2, PCD2, PCPlus4D2;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .ImemReq(ImemReq),
    .ImemAddr(ImemAddr), .ImemRValid(ImemRValid), .ImemRData(ImemRData),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  // Same control inputs, PC starting at the top of the address space.
  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .ImemReq(ImemReq2),
    .ImemAddr(ImemAddr2), .ImemRValid(ImemRValid), .ImemRData(ImemRData),
    .InstrD(InstrD2), .PCD(PCD2), .PCPlus4D(PCPlus4D2), .ValidD(ValidD2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: fetch PC, outstanding request, skid slot, IF/ID contents.
  bit          mIdle, mPend, mDiscard, mSkidV, mValid;
  logic [31:0] mPc, mSkidInstr, mSkidPc, mInstr, mPcD, mPc4D;
  // Instruction memory: one outstanding request, fixed latency.
  int          memLat = 1;
  int          memRem = 0;
  logic [31:0] memAddr = 32'h0;
  bit          forceRv = 1'b0;
  logic [31:0] forceData = 32'h0;
  // Values sampled in the most recent cycle.
  logic        sReq, sValid, s2Req, s2Valid;
  logic [31:0] sAddr, sInstr, sPcD, sPc4D, s2Addr, s2Instr, s2PcD, s2Pc4;

  function automatic logic [31:0] memData(input logic [31:0] a);
    if (a == 32'h40) return 32'h00A0_0093;
    return {a[31:2], 2'b11} ^ 32'h5A00_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mIdle = 1'b1; mPend = 1'b0; mDiscard = 1'b0; mSkidV = 1'b0;
    mPc = 32'h0; mInstr = NOP; mPcD = 32'h0; mPc4D = 32'h0; mValid = 1'b0;
    memRem = 0;
  endtask

  // One clock cycle: drive, check against the model, then advance the model.
  task automatic step(input bit s, input bit d, input bit p, input logic [31:0] tgt);
    bit          reqExp, redir, resp, loaded;
    logic [31:0] li, lp;
    @(negedge clk);
    StallF = s; StallD = d; PCSrcD = p; PCBranchD = tgt;
    ImemRValid = forceRv || (memRem == 1);
    ImemRData  = forceRv ? forceData : memData(memAddr);
    #1;
    redir  = p && !d;
    reqExp = !mIdle && !mPend && !mSkidV && !s && !redir;
    sReq = ImemReq; sAddr = ImemAddr; sInstr = InstrD; sPcD = PCD;
    sPc4D = PCPlus4D; sValid = ValidD;
    s2Req = ImemReq2; s2Addr = ImemAddr2; s2Instr = InstrD2; s2PcD = PCD2;
    s2Pc4 = PCPlus4D2; s2Valid = ValidD2;
    check("ImemReq", 32'(ImemReq), 32'(reqExp));
    if (reqExp) check("ImemAddr", ImemAddr, mPc);
    check("InstrD", InstrD, mInstr);
    check("PCD", PCD, mPcD);
    check("PCPlus4D", PCPlus4D, mPc4D);
    check("ValidD", 32'(ValidD), 32'(mValid));
    @(posedge clk);
    if (memRem > 0) memRem--;
    if (sReq) begin memRem = memLat; memAddr = sAddr; end
    resp = ImemRValid && mPend;
    loaded = 1'b0; li = 32'h0; lp = 32'h0;
    if (redir) begin
      mPc = tgt; mInstr = NOP; mValid = 1'b0; mSkidV = 1'b0;
      if (mPend) begin
        if (resp) begin mPend = 1'b0; mDiscard = 1'b0; end
        else mDiscard = 1'b1;
      end
    end else begin
      if (resp && mDiscard) begin
        mPend = 1'b0; mDiscard = 1'b0;
      end else if (resp) begin
        mPend = 1'b0;
        if (!d) begin
          loaded = 1'b1; li = ImemRData; lp = mPc; mPc = mPc + 32'd4;
        end
`ifdef FETCH_SKID_EN
        else begin
          mSkidV = 1'b1; mSkidInstr = ImemRData; mSkidPc = mPc; mPc = mPc + 32'd4;
        end
`endif
      end else if (mSkidV && !d) begin
        loaded = 1'b1; li = mSkidInstr; lp = mSkidPc; mSkidV = 1'b0;
      end
      if (!d) begin
        if (loaded) begin
          mInstr = li; mPcD = lp; mPc4D = lp + 32'd4; mValid = 1'b1;
        end else begin
          mInstr = NOP; mValid = 1'b0;
        end
      end
      if (reqExp) mPend = 1'b1;
    end
    mIdle = 1'b0;
  endtask

  // Asynchronous reset asserted mid-cycle; released just after a rising edge.
  task automatic pulseReset();
    @(negedge clk);
    #2;
    rst_n = 1'b0; forceRv = 1'b0; ImemRValid = 1'b0; PCSrcD = 1'b0;
    modelReset();
    #1;
    check("rst_ImemReq", 32'(ImemReq), 32'h0);
    check("rst_ImemAddr", ImemAddr, 32'h0);
    check("rst_ImemAddr2", ImemAddr2, 32'hFFFF_FFFC);
    check("rst_InstrD", InstrD, NOP);
    check("rst_PCD", PCD, 32'h0);
    check("rst_PCPlus4D", PCPlus4D, 32'h0);
    check("rst_ValidD", 32'(ValidD), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit bubbleOk;
    modelReset();

    // Reset release, L=1, no stalls, stale response in IDLE.
    memLat = 1;
    pulseReset();
    forceRv = 1'b1; forceData = 32'hDEAD_BEEF;
    step(0, 0, 0, 0);
    forceRv = 1'b0;
    check("lit_idle_req", 32'(sReq), 32'h0);
    check("lit_idle_valid", 32'(sValid), 32'h0);
    step(0, 0, 0, 0);
    check("lit_req0", 32'(sReq), 32'h1);
    check("lit_addr0", sAddr, 32'h0);
    check("lit_req0_dut2", 32'(s2Req), 32'h1);
    check("lit_addr0_dut2", s2Addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("lit_instr0", sInstr, 32'h5A00_0003);
    check("lit_valid0", 32'(sValid), 32'h1);
    check("lit_pcd0", sPcD, 32'h0);
    check("lit_addr1", sAddr, 32'h4);
    check("lit_wrap_addr_dut2", s2Addr, 32'h0);
    check("lit_wrap_pc4_dut2", s2Pc4, 32'h0);
    check("lit_wrap_pcd_dut2", s2PcD, 32'hFFFF_FFFC);
    check("lit_wrap_valid_dut2", 32'(s2Valid), 32'h1);
    check("lit_wrap_instr_dut2", s2Instr, 32'h5A00_0003);
    step(0, 0, 0, 0);
    check("lit_bubble_valid", 32'(sValid), 32'h0);
    check("lit_bubble_pcd", sPcD, 32'h0);
    step(0, 0, 0, 0);
    check("lit_addr2", sAddr, 32'h8);
    check("lit_pcd1", sPcD, 32'h4);
    check("lit_instr1", sInstr, 32'h5A00_0007);

    // Redirect to 0x100 while waiting, L=3: in-flight response dropped.
    pulseReset();
    memLat = 3;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h100);
    n = 0; bubbleOk = 1'b1;
    do begin
      step(0, 0, 0, 0);
      n++;
      if (sValid !== 1'b0 || sInstr !== NOP) bubbleOk = 1'b0;
    end while (!sReq && n < 10);
    check("lit_redir_cycles", n, 3);
    check("lit_redir_addr", sAddr, 32'h100);
    check("lit_redir_bubbles", 32'(bubbleOk), 32'h1);
    n = 0;
    do begin step(0, 0, 0, 0); n++; end while (!sValid && n < 10);
    check("lit_redir_pcd", sPcD, 32'h100);
    check("lit_redir_instr", sInstr, memData(32'h100));

    // Decode and fetch stalled for 3 cycles as 0x00A00093 arrives.
    pulseReset();
    memLat = 1;
    step(0, 0, 1, 32'h40);
    step(0, 0, 0, 0);
    check("lit_stall_addr", sAddr, 32'h40);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    check("lit_stall_hold_valid", 32'(sValid), 32'h0);
    step(0, 0, 0, 0);
`ifdef FETCH_SKID_EN
    check("lit_skid_noreq", 32'(sReq), 32'h0);
    step(0, 0, 0, 0);
    check("lit_skid_instr", sInstr, 32'h00A0_0093);
    check("lit_skid_pcd", sPcD, 32'h40);
    check("lit_skid_next_addr", sAddr, 32'h44);
`else
    check("lit_refetch_req", 32'(sReq), 32'h1);
    check("lit_refetch_addr", sAddr, 32'h40);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("lit_refetch_instr", sInstr, 32'h00A0_0093);
    check("lit_refetch_pcd", sPcD, 32'h40);
`endif

    // Branch while decode stalled is ignored; taken once StallD drops.
    pulseReset();
    memLat = 1;
    step(0, 0, 0, 0);
    step(1, 1, 1, 32'h200);
    check("lit_bstall_noreq", 32'(sReq), 32'h0);
    step(0, 1, 1, 32'h200);
    check("lit_bstall_addr", sAddr, 32'h0);
    step(0, 0, 1, 32'h200);
    check("lit_bredir_noreq", 32'(sReq), 32'h0);
    step(0, 0, 0, 0);
    check("lit_bredir_addr", sAddr, 32'h200);
    check("lit_bredir_valid", 32'(sValid), 32'h0);

    // Reset pulsed mid-WAIT, stale response afterwards in IDLE.
    memLat = 3;
    pulseReset();
    forceRv = 1'b1; forceData = 32'hBAD0_0BAD;
    step(0, 0, 0, 0);
    forceRv = 1'b0;
    check("lit_stale_valid", 32'(sValid), 32'h0);
    step(0, 0, 0, 0);
    check("lit_stale_addr", sAddr, 32'h0);
    check("lit_stale_req", 32'(sReq), 32'h1);

    // Randomized traffic over several latencies.
    for (int lat = 1; lat <= 4; lat++) begin
      memLat = lat;
      for (int c = 0; c < 500; c++) begin
        bit s, d, p;
        logic [31:0] tgt;
        if ($urandom_range(0, 299) == 0) pulseReset();
        s = ($urandom_range(0, 3) == 0);
        d = ($urandom_range(0, 4) == 0) ? !s : s;
        p = ($urandom_range(0, 7) == 0);
        tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
        step(s, d, p, tgt);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
